bp_be_issue_queue_mw: RTL and testbench
=======================================

BP_BE_ISSUE_QUEUE_MW -- requirements
Module: bp_be_issue_queue_mw

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter els_p, default 8, queue depth in entries; SHALL be a power of 2, at least 2.
REQ-003 Parameter width_p, default 64, entry width in bits.
REQ-004 Parameter issue_width_p, default 2, maximum entries presented and consumed per cycle; SHALL be in the range 1..4 and at most els_p.
REQ-005 Derived widths: ptr_w = clog2(els_p)+1; cnt_w = clog2(issue_width_p+1); occ_w = clog2(els_p+1).
REQ-006 Ports (name, direction, width, meaning):
- clk_i, in, 1: clock, rising edge.
- reset_n_i, in, 1: asynchronous active-low reset.
- enq_v_i, in, 1: enqueue valid.
- enq_data_i, in, width_p: enqueue entry.
- enq_ready_and_o, out, 1: enqueue ready; the transfer occurs when enq_v_i & enq_ready_and_o.
- issue_data_o, out, issue_width_p*width_p: slot i = entry at rptr+i.
- issue_v_o, out, issue_width_p: thermometer-coded slot valid.
- read_cnt_i, in, cnt_w: entries consumed speculatively this cycle.
- cmt_cnt_i, in, cnt_w: entries committed this cycle.
- roll_i, in, 1: rewind the read pointer to the checkpoint.
- clr_i, in, 1: flush all entries.
- occupancy_o, out, occ_w: number of allocated entries.

Function
REQ-007 The block SHALL keep three pointers of ptr_w bits, each with a wrap MSB: wptr (write), rptr (speculative read) and cptr (checkpoint/commit). All pointer arithmetic SHALL be modulo 2*els_p.
REQ-008 The queue SHALL be full when wptr - cptr == els_p, and readable-empty when rptr == wptr.
REQ-009 enq_ready_and_o SHALL equal ~full, computed from registered pointers only; a commit in the same cycle SHALL NOT free space until the next cycle.
REQ-010 On an accepted enqueue, the block SHALL write mem[wptr mod els_p] and set wptr += 1 at the next edge.
REQ-011 issue_v_o[i] SHALL be 1 iff (wptr - rptr) > i, and issue_data_o slot i SHALL be mem[(rptr+i) mod els_p], read combinationally.
REQ-012 Data written in cycle N SHALL first appear on issue_data_o in cycle N+1; there is no same-cycle bypass.
REQ-013 The effective read count SHALL be min(read_cnt_i, wptr - rptr), and rptr SHALL advance by that amount.
REQ-014 The effective commit count SHALL be min(cmt_cnt_i, rptr - cptr), and cptr SHALL advance by that amount.
REQ-015 On roll_i, rptr_next SHALL be cptr + effective commit count; read_cnt_i SHALL be ignored; enqueue and commit SHALL proceed normally.
REQ-016 On clr_i, wptr, rptr and cptr SHALL all be 0 at the next edge; enqueue, read, commit and roll SHALL be ignored in that cycle; enq_ready_and_o SHALL be unaffected in that cycle.
REQ-017 Priority SHALL be clr_i > roll_i > read for rptr, and clr_i > normal update for wptr and cptr.
REQ-018 occupancy_o SHALL equal wptr - cptr using registered pointers, with a range of 0..els_p.
REQ-019 Memory contents SHALL NOT be reset; unused slots MAY carry stale data, masked by issue_v_o.
REQ-020 Simultaneous enqueue, read and commit SHALL all take effect in the same cycle, including across pointer wrap.

Reset
REQ-021 Assertion of reset_n_i low SHALL immediately, without a clock edge, force wptr = rptr = cptr = 0.
REQ-022 During and after reset: issue_v_o = 0, enq_ready_and_o = 1, occupancy_o = 0, and issue_data_o is don't-care.
REQ-023 After reset deasserts, operation SHALL resume on the first rising edge; reset asserted mid-operation SHALL discard all entries.

Verification
REQ-024 Fill (els_p=8, issue_width_p=2): 8 enqueues with no reads -> enq_ready_and_o=0 and occupancy_o=8; a 9th enq_v_i is not accepted.
REQ-025 Dual issue: enqueue A,B,C; then read_cnt_i=2 -> next cycle slot0=C, issue_v_o=2'b01; then read_cnt_i=2 -> rptr advances by 1 only.
REQ-026 Roll: enqueue 4, read 3, commit 1, then roll_i with cmt_cnt_i=1 -> rptr=cptr=2, issue_v_o=2'b11, slot0 = third entry.
REQ-027 Wrap: run 20 enqueue/read/commit cycles with pointers crossing 2*els_p -> data order is preserved and full/empty are correct at every cycle.
REQ-028 Clear versus async reset: clr_i with occupancy_o=5 -> occupancy_o=0 at the next edge; a pulse of reset_n_i between edges -> issue_v_o=0 before the next edge.
REQ-029 Over-commit: cmt_cnt_i=2 with rptr - cptr = 1 -> cptr advances by 1 only, and occupancy_o drops by 1.

Source files
------------

// File: rtl/bp_be_issue_queue_mw.sv
// rtl/bp_be_issue_queue_mw.sv - multi-wide issue queue with speculative read and commit pointers
// Ports:
//   clk_i, reset_n_i              clock, asynchronous active-low reset
//   enq_v_i, enq_data_i           enqueue request and entry
//   enq_ready_and_o               space available (registered pointers only)
//   issue_data_o, issue_v_o       up to issue_width_p entries from rptr, thermometer valid
//   read_cnt_i, cmt_cnt_i         speculative consume / commit counts
//   roll_i, clr_i                 rewind rptr to checkpoint / flush all entries
//   occupancy_o                   allocated entries (wptr - cptr)
module bp_be_issue_queue_mw #(
  parameter int els_p         = 8,
  parameter int width_p       = 64,
  parameter int issue_width_p = 2,
  localparam int ptr_w        = $clog2(els_p) + 1,
  localparam int cnt_w        = $clog2(issue_width_p + 1),
  localparam int occ_w        = $clog2(els_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             enq_v_i,
  input  logic [width_p-1:0]               enq_data_i,
  output logic                             enq_ready_and_o,
  output logic [issue_width_p*width_p-1:0] issue_data_o,
  output logic [issue_width_p-1:0]         issue_v_o,
  input  logic [cnt_w-1:0]                 read_cnt_i,
  input  logic [cnt_w-1:0]                 cmt_cnt_i,
  input  logic                             roll_i,
  input  logic                             clr_i,
  output logic [occ_w-1:0]                 occupancy_o
);

  localparam int idx_w = $clog2(els_p);

  logic [ptr_w-1:0]   wptr_q, wptr_d;
  logic [ptr_w-1:0]   rptr_q, rptr_d;
  logic [ptr_w-1:0]   cptr_q, cptr_d;
  logic [width_p-1:0] mem_q [els_p];

  logic [ptr_w-1:0] alloc_cnt;   // wptr - cptr
  logic [ptr_w-1:0] avail_cnt;   // wptr - rptr, entries readable
  logic [ptr_w-1:0] spec_cnt;    // rptr - cptr, entries read but not committed
  logic [ptr_w-1:0] rd_req, cm_req, rd_eff, cm_eff;
  logic             full;
  logic             wr_en;

  // Pointers carry a wrap bit, so plain ptr_w-bit subtraction is modulo 2*els_p.
  assign alloc_cnt = wptr_q - cptr_q;
  assign avail_cnt = wptr_q - rptr_q;
  assign spec_cnt  = rptr_q - cptr_q;
  assign full      = (alloc_cnt == ptr_w'(els_p));

  assign enq_ready_and_o = ~full;
  assign occupancy_o     = occ_w'(alloc_cnt);
  assign wr_en           = enq_v_i & ~full & ~clr_i;

  assign rd_req = ptr_w'(read_cnt_i);
  assign cm_req = ptr_w'(cmt_cnt_i);
  assign rd_eff = (rd_req < avail_cnt) ? rd_req : avail_cnt;
  assign cm_eff = (cm_req < spec_cnt)  ? cm_req : spec_cnt;

  always_comb begin
    issue_v_o    = '0;
    issue_data_o = '0;
    for (int i = 0; i < issue_width_p; i++) begin
      logic [ptr_w-1:0] slot_ptr;
      slot_ptr = rptr_q + ptr_w'(i);
      issue_v_o[i] = (avail_cnt > ptr_w'(i));
      issue_data_o[i*width_p +: width_p] = mem_q[slot_ptr[idx_w-1:0]];
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cptr_d = '0;
    end else begin
      if (wr_en) begin
        wptr_d = wptr_q + 1'b1;
      end
      cptr_d = cptr_q + cm_eff;
      // A rollback lands just past whatever commits in the same cycle.
      rptr_d = roll_i ? (cptr_q + cm_eff) : (rptr_q + rd_eff);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Storage is intentionally not reset; stale slots are masked by issue_v_o.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q[idx_w-1:0]] <= enq_data_i;
    end
  end

endmodule

// File: tb/tb_bp_be_issue_queue_mw.sv
// tb/tb_bp_be_issue_queue_mw.sv - self-checking bench for bp_be_issue_queue_mw
module tb_bp_be_issue_queue_mw;

  localparam int ELS = 8;
  localparam int W   = 64;
  localparam int IW  = 2;
  localparam int CW  = 2;
  localparam int OW  = 4;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          enq_v_i;
  logic [W-1:0]  enq_data_i;
  logic          enq_ready_and_o;
  logic [IW*W-1:0] issue_data_o;
  logic [IW-1:0] issue_v_o;
  logic [CW-1:0] read_cnt_i;
  logic [CW-1:0] cmt_cnt_i;
  logic          roll_i;
  logic          clr_i;
  logic [OW-1:0] occupancy_o;

  always #5 clk = ~clk;

  bp_be_issue_queue_mw #(.els_p(ELS), .width_p(W), .issue_width_p(IW)) dut (
    .clk_i(clk),
    .reset_n_i(reset_n_i),
    .enq_v_i(enq_v_i),
    .enq_data_i(enq_data_i),
    .enq_ready_and_o(enq_ready_and_o),
    .issue_data_o(issue_data_o),
    .issue_v_o(issue_v_o),
    .read_cnt_i(read_cnt_i),
    .cmt_cnt_i(cmt_cnt_i),
    .roll_i(roll_i),
    .clr_i(clr_i),
    .occupancy_o(occupancy_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: unbounded sequence numbers for written, read and committed entries.
  int mw = 0;
  int mr = 0;
  int mc = 0;
  logic [W-1:0] store [int];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_v;
    chk("enq_ready", W'(enq_ready_and_o), W'((mw - mc) != ELS));
    chk("occupancy", W'(occupancy_o), W'(mw - mc));
    for (int i = 0; i < IW; i++) begin
      exp_v = ((mw - mr) > i);
      chk("issue_v", W'(issue_v_o[i]), W'(exp_v));
      if (exp_v) chk("issue_data", issue_data_o[i*W +: W], store[mr + i]);
    end
  endtask

  task automatic idle_inputs();
    enq_v_i    = 1'b0;
    enq_data_i = '0;
    read_cnt_i = '0;
    cmt_cnt_i  = '0;
    roll_i     = 1'b0;
    clr_i      = 1'b0;
  endtask

  task automatic cycle(input logic ev, input logic [W-1:0] d, input int rd, input int cm,
                       input logic rl, input logic cl);
    int ow, orr, oc, ce, re;
    enq_v_i    = ev;
    enq_data_i = d;
    read_cnt_i = CW'(rd);
    cmt_cnt_i  = CW'(cm);
    roll_i     = rl;
    clr_i      = cl;
    @(negedge clk);
    check_outputs();
    ow = mw; orr = mr; oc = mc;
    if (cl) begin
      mw = 0; mr = 0; mc = 0;
    end else begin
      if (ev && (ow - oc) != ELS) begin
        store[ow] = d;
        mw = ow + 1;
      end
      ce = (cm < (orr - oc)) ? cm : (orr - oc);
      re = (rd < (ow - orr)) ? rd : (ow - orr);
      mr = rl ? (oc + ce) : (orr + re);
      mc = oc + ce;
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    reset_n_i = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_issue_v", W'(issue_v_o), '0);
    chk("reset_ready", W'(enq_ready_and_o), W'(1));
    chk("reset_occ", W'(occupancy_o), '0);
    @(negedge clk);
    reset_n_i = 1'b1;
    @(posedge clk);
    #1;

    // Fill: 8 enqueues then a rejected 9th.
    for (int i = 0; i < ELS; i++) cycle(1'b1, W'(64'h100 + i), 0, 0, 1'b0, 1'b0);
    chk("fill_ready", W'(enq_ready_and_o), '0);
    chk("fill_occ", W'(occupancy_o), W'(8));
    cycle(1'b1, 64'hDEAD, 0, 0, 1'b0, 1'b0);
    chk("fill_9th_occ", W'(occupancy_o), W'(8));

    // Dual issue.
    cycle(1'b0, '0, 0, 0, 1'b0, 1'b1);
    cycle(1'b1, 64'hA, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 64'hB, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 64'hC, 0, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, 2, 0, 1'b0, 1'b0);
    chk("dual_slot0", issue_data_o[W-1:0], 64'hC);
    chk("dual_v", W'(issue_v_o), W'(2'b01));
    cycle(1'b0, '0, 2, 0, 1'b0, 1'b0);
    chk("dual_drained_v", W'(issue_v_o), '0);

    // Roll.
    cycle(1'b0, '0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(64'h200 + i), 0, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, 3, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, 0, 1, 1'b0, 1'b0);
    cycle(1'b0, '0, 3, 1, 1'b1, 1'b0);
    chk("roll_v", W'(issue_v_o), W'(2'b11));
    chk("roll_slot0", issue_data_o[W-1:0], 64'h202);
    chk("roll_occ", W'(occupancy_o), W'(2));

    // Over-commit.
    cycle(1'b0, '0, 0, 0, 1'b0, 1'b1);
    cycle(1'b1, 64'h300, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 64'h301, 0, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, 0, 2, 1'b0, 1'b0);
    chk("overcommit_occ", W'(occupancy_o), W'(1));
    chk("overcommit_slot0", issue_data_o[W-1:0], 64'h301);

    // Wrap: steady enqueue/read/commit traffic crossing 2*els_p.
    for (int i = 0; i < 20; i++) cycle(1'b1, W'(64'h400 + i), 1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, W'(64'h500 + i), 2, 2, 1'b0, 1'b0);

    // Clear with occupancy 5.
    cycle(1'b0, '0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(64'h600 + i), 0, 0, 1'b0, 1'b0);
    chk("pre_clr_occ", W'(occupancy_o), W'(5));
    cycle(1'b1, 64'h6FF, 2, 2, 1'b1, 1'b1);
    chk("clr_occ", W'(occupancy_o), '0);

    // Async reset pulse between edges.
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(64'h700 + i), 0, 0, 1'b0, 1'b0);
    #2 reset_n_i = 1'b0;
    #1;
    chk("async_rst_v", W'(issue_v_o), '0);
    chk("async_rst_occ", W'(occupancy_o), '0);
    chk("async_rst_ready", W'(enq_ready_and_o), W'(1));
    #1 reset_n_i = 1'b1;
    mw = 0; mr = 0; mc = 0;
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), {$urandom, $urandom},
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
